key_debounce_8: RTL

- Upstream input-conditioning stage for the 8-to-3 priority encoder.
- Takes 8 raw switch/button lines and synchronises each to clk.
- Debounces each line independently and presents a clean, stable 8-bit vector to the encoder input.
- Also emits one-cycle press pulses so downstream logic can react to new requests without edge detection of its own.

---
 rtl/key_pkg.sv | 11 +
 rtl/debounce_cell.sv | 50 +++++
 rtl/key_debounce_8.sv | 44 ++++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared key-input constants and configuration check for the key debouncer and encoder.
package key_pkg;
    localparam int NUM_KEYS    = 8;
    localparam int CNT_MAX_DEF = 500000;
    localparam int CNT_W_DEF   = 20;

    function automatic bit cnt_fits(input int cnt_max, input int cnt_w);
        return cnt_max >= 2 && cnt_w > 0 && cnt_w < 62 &&
               (longint'(cnt_max) - 1) < (longint'(1) << cnt_w);
    endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one channel with 2-flop sync, stability counter, level and press pulse.
// Release pulse output exists only when KEY_RELEASE_PULSE_EN is defined.
import key_pkg::*;

module debounce_cell #(
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic level,
    output logic level_nxt,
    output logic press
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic rel
`endif
);
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic             differ, term;

    assign differ    = sync2 != level;
    assign term      = cnt == CNT_W'(CNT_MAX - 1);
    assign level_nxt = (differ && term) ? sync2 : level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            rel   <= 1'b0;
`endif
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            // any agreement or an accepted change restarts the count
            cnt   <= (differ && !term) ? cnt + 1'b1 : '0;
            level <= level_nxt;
            press <= level_nxt & ~level;
`ifdef KEY_RELEASE_PULSE_EN
            rel   <= ~level_nxt & level;
`endif
        end
    end
endmodule

// File: rtl/key_debounce_8.sv
// key_debounce_8: eight independent debounced key channels feeding the priority encoder.
// Defining KEY_RELEASE_PULSE_EN adds the key_release pulse output.
import key_pkg::*;

module key_debounce_8 #(
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press,
`ifdef KEY_RELEASE_PULSE_EN
    output logic [NUM_KEYS-1:0] key_release,
`endif
    output logic                key_any
);
    logic [NUM_KEYS-1:0] lvl_nxt;

    if (!cnt_fits(CNT_MAX, CNT_W)) begin : g_bad_cfg
        $error("key_debounce_8: CNT_MAX must be >= 2 and CNT_MAX-1 must fit in CNT_W bits");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        debounce_cell #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) u_cell (
            .clk       (clk),
            .rst       (rst),
            .key_in    (key_in[i]),
            .level     (key_out[i]),
            .level_nxt (lvl_nxt[i]),
            .press     (key_press[i])
`ifdef KEY_RELEASE_PULSE_EN
            ,
            .rel       (key_release[i])
`endif
        );
    end

    // taken from next-state levels so key_any moves with key_out
    always_ff @(posedge clk) begin
        key_any <= rst ? 1'b0 : |lvl_nxt;
    end
endmodule
